// File: rtl/hazard_ctrl_pkg.sv
// Shared decode/hazard definitions: register-file size, long-op limits, long-op class.
package hazard_ctrl_pkg;

    localparam int GPR_N       = 32;
    localparam int MAX_OUT_DEF = 2;
    localparam int CNT_W_DEF   = 2;

    typedef logic [4:0] reg_idx_t;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // Long-latency class: every load, plus div/divu/rem/remu (M-extension funct3 1xx).
    function automatic logic is_long_op(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic [6:0] funct7);
        return (opcode == OPC_LOAD) ||
               ((opcode == OPC_OP) && (funct7 == F7_MULDIV) && funct3[2]);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode / writeback / hazard-status bundle between the pipeline and hazard_ctrl.
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();
    logic             dec_valid_i;
    reg_idx_t         dec_rs1_raddr_i;
    reg_idx_t         dec_rs2_raddr_i;
    reg_idx_t         dec_rd_waddr_i;
    logic             dec_rd_we_i;
    logic             dec_long_i;
    logic             flush_i;
    logic             wb_valid_i;
    reg_idx_t         wb_waddr_i;
    logic             stall_o;
    logic [GPR_N-1:0] pending_o;
    logic [CNT_W-1:0] outstanding_o;
    logic             err_o;

    modport master (
        output dec_valid_i, dec_rs1_raddr_i, dec_rs2_raddr_i, dec_rd_waddr_i,
               dec_rd_we_i, dec_long_i, flush_i, wb_valid_i, wb_waddr_i,
        input  stall_o, pending_o, outstanding_o, err_o
    );

    modport slave (
        input  dec_valid_i, dec_rs1_raddr_i, dec_rs2_raddr_i, dec_rd_waddr_i,
               dec_rd_we_i, dec_long_i, flush_i, wb_valid_i, wb_waddr_i,
        output stall_o, pending_o, outstanding_o, err_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Long-latency RAW/WAW scoreboard plus outstanding-op limiter; stall is combinational
// from registered state only, so a writeback releases a stall one cycle later.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_ctrl_if.slave hz
);
    logic [GPR_N-1:0] pending_q;
    logic [GPR_N-1:0] pending_d;
    logic [GPR_N-1:0] set_mask;
    logic [GPR_N-1:0] clr_mask;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;
    logic             raw;
    logic             waw;
    logic             full;
    logic             stall;
    logic             issue_long;
    logic             wb_dec;
    logic             rd_tracked;

    assign raw  = ((hz.dec_rs1_raddr_i != '0) && pending_q[hz.dec_rs1_raddr_i]) ||
                  ((hz.dec_rs2_raddr_i != '0) && pending_q[hz.dec_rs2_raddr_i]);
    assign waw  = hz.dec_rd_we_i && (hz.dec_rd_waddr_i != '0) && pending_q[hz.dec_rd_waddr_i];
    assign full = hz.dec_long_i && (cnt_q == CNT_W'(MAX_OUT));

    // flush_i is the only non-registered term that reaches the stall.
    assign stall      = hz.dec_valid_i && !hz.flush_i && (raw || waw || full);
    assign issue_long = hz.dec_valid_i && !hz.flush_i && !stall && hz.dec_long_i;
    assign rd_tracked = hz.dec_rd_we_i && (hz.dec_rd_waddr_i != '0);
    assign wb_dec     = hz.wb_valid_i && (cnt_q != '0);

    assign set_mask  = (issue_long && rd_tracked) ? (GPR_N'(1) << hz.dec_rd_waddr_i) : '0;
    assign clr_mask  = hz.wb_valid_i ? (GPR_N'(1) << hz.wb_waddr_i) : '0;
    // Set is applied after clear so it wins on a same-index collision; x0 is never tracked.
    assign pending_d = ((pending_q & ~clr_mask) | set_mask) & {{(GPR_N-1){1'b1}}, 1'b0};

    always_comb begin
        cnt_d = cnt_q;
        if (issue_long && !wb_dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!issue_long && wb_dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            if (hz.wb_valid_i && (cnt_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign hz.stall_o       = stall;
    assign hz.pending_o     = pending_q;
    assign hz.outstanding_o = cnt_q;
    assign hz.err_o         = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios then random traffic against an in-order queue model of in-flight long ops.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int MAXO = 2;
    localparam int CW   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hz ();
    hazard_ctrl #(.MAX_OUT(MAXO), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));

    int n_chk  = 0;
    int n_fail = 0;

    // Destination of each in-flight long op, oldest first; 0 means untracked destination.
    logic [4:0] q[$];
    logic       m_err = 1'b0;

    function automatic logic in_flight(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (q[i]) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        for (int r = 1; r < 32; r++) p[r] = in_flight(5'(r));
        return p;
    endfunction

    function automatic logic m_stall();
        logic hazard;
        hazard = in_flight(hz.dec_rs1_raddr_i) || in_flight(hz.dec_rs2_raddr_i) ||
                 (hz.dec_rd_we_i && in_flight(hz.dec_rd_waddr_i)) ||
                 (hz.dec_long_i && (q.size() == MAXO));
        return hz.dec_valid_i && !hz.flush_i && hazard;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_stall"}, 32'(hz.stall_o), 32'(m_stall()));
        chk({tag, "_pend"}, hz.pending_o, m_pend());
        chk({tag, "_out"}, 32'(hz.outstanding_o), 32'(q.size()));
        chk({tag, "_err"}, 32'(hz.err_o), 32'(m_err));
    endtask

    task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic we, input logic lg,
                       input logic fl, input logic wv, input logic [4:0] wa);
        hz.dec_valid_i     = v;
        hz.dec_rs1_raddr_i = r1;
        hz.dec_rs2_raddr_i = r2;
        hz.dec_rd_waddr_i  = rd;
        hz.dec_rd_we_i     = we;
        hz.dec_long_i      = lg;
        hz.flush_i         = fl;
        hz.wb_valid_i      = wv;
        hz.wb_waddr_i      = wa;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wb(input logic [4:0] a);
        drv(0, 0, 0, 0, 0, 0, 0, 1, a);
    endtask

    // Advance one clock, updating the model from the inputs seen before the edge.
    task automatic step();
        logic       iss_long;
        logic [4:0] rde;
        logic       wbv;
        iss_long = hz.dec_valid_i && !hz.flush_i && !m_stall() && hz.dec_long_i;
        rde      = hz.dec_rd_we_i ? hz.dec_rd_waddr_i : 5'd0;
        wbv      = hz.wb_valid_i;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (wbv) begin
                if (q.size() == 0) m_err = 1'b1;
                else void'(q.pop_front());
            end
            if (iss_long) q.push_back(rde);
        end
    endtask

    task automatic cyc(input string tag);
        #1;
        check_all(tag);
        step();
    endtask

    initial begin
        // Reset, with junk on the decode side.
        drv(1, 3, 4, 5, 1, 1, 0, 1, 6);
        step();
        idle();
        step();
        #1;
        chk("rst_pend", hz.pending_o, 32'h0);
        chk("rst_out", 32'(hz.outstanding_o), 32'd0);
        chk("rst_err", 32'(hz.err_o), 32'd0);
        chk("rst_stall", 32'(hz.stall_o), 32'd0);
        rst_n = 1'b1;
        step();

        // lw x5 ; add x6,x5,x1 stalls until the cycle after wb x5.
        drv(1, 1, 0, 5, 1, 1, 0, 0, 0);
        #1; chk("lw5_stall", 32'(hz.stall_o), 32'd0);
        cyc("lw5");
        chk("lw5_pend", hz.pending_o, 32'h20);
        drv(1, 5, 1, 6, 1, 0, 0, 0, 0);
        #1; chk("raw5_stall", 32'(hz.stall_o), 32'd1);
        cyc("raw5_a");
        cyc("raw5_b");
        drv(1, 5, 1, 6, 1, 0, 0, 1, 5);
        #1; chk("raw5_wb_stall", 32'(hz.stall_o), 32'd1);
        cyc("raw5_wb");
        drv(1, 5, 1, 6, 1, 0, 0, 0, 0);
        #1;
        chk("raw5_rel_stall", 32'(hz.stall_o), 32'd0);
        chk("raw5_rel_pend", hz.pending_o, 32'h0);
        cyc("raw5_rel");

        // div x7, div x8, div x9: third is full until wb x7.
        drv(1, 2, 3, 7, 1, 1, 0, 0, 0); cyc("div7");
        drv(1, 2, 3, 8, 1, 1, 0, 0, 0); cyc("div8");
        drv(1, 2, 3, 9, 1, 1, 0, 0, 0);
        #1;
        chk("div9_full", 32'(hz.stall_o), 32'd1);
        chk("div9_out", 32'(hz.outstanding_o), 32'd2);
        cyc("div9_a");
        drv(1, 2, 3, 9, 1, 1, 0, 1, 7);
        #1; chk("div9_wb_stall", 32'(hz.stall_o), 32'd1);
        cyc("div9_wb");
        drv(1, 2, 3, 9, 1, 1, 0, 0, 0);
        #1; chk("div9_go", 32'(hz.stall_o), 32'd0);
        cyc("div9_go");
        idle();
        #1;
        chk("div9_out2", 32'(hz.outstanding_o), 32'd2);
        chk("div9_pend", hz.pending_o, 32'h300);
        cyc("div_idle");
        wb(8); cyc("wb8");
        wb(9); cyc("wb9");

        // WAW on x3, RAW through rd=x0, independent addi.
        drv(1, 0, 0, 3, 1, 1, 0, 0, 0); cyc("lw3");
        drv(1, 1, 0, 3, 1, 1, 0, 0, 0);
        #1; chk("waw3", 32'(hz.stall_o), 32'd1);
        cyc("waw3");
        drv(1, 3, 3, 0, 1, 0, 0, 0, 0);
        #1; chk("raw3_x0", 32'(hz.stall_o), 32'd1);
        cyc("raw3_x0");
        drv(1, 0, 0, 4, 1, 0, 0, 0, 0);
        #1; chk("addi4", 32'(hz.stall_o), 32'd0);
        cyc("addi4");
        wb(3); cyc("wb3");

        // Flush masks the stall but keeps scoreboard state.
        drv(1, 0, 0, 10, 1, 1, 0, 0, 0); cyc("lw10");
        drv(1, 10, 0, 11, 1, 1, 1, 0, 0);
        #1; chk("flush_stall", 32'(hz.stall_o), 32'd0);
        cyc("flush");
        #1;
        chk("flush_pend", hz.pending_o, 32'h400);
        chk("flush_out", 32'(hz.outstanding_o), 32'd1);
        wb(10); cyc("wb10");

        // Same-cycle wb x11 and issue lw x12.
        drv(1, 0, 0, 11, 1, 1, 0, 0, 0); cyc("lw11");
        drv(1, 1, 2, 12, 1, 1, 0, 1, 11); cyc("wb11_lw12");
        #1;
        chk("swap_out", 32'(hz.outstanding_o), 32'd1);
        chk("swap_pend", hz.pending_o, 32'h1000);
        wb(12); cyc("wb12");

        // Writeback with nothing outstanding; untracked rd=x0 long op.
        wb(7); cyc("err_wb");
        #1;
        chk("err_set", 32'(hz.err_o), 32'd1);
        chk("err_out", 32'(hz.outstanding_o), 32'd0);
        idle(); cyc("err_hold_a"); cyc("err_hold_b");
        drv(1, 1, 0, 0, 1, 1, 0, 0, 0); cyc("lw0");
        #1;
        chk("lw0_out", 32'(hz.outstanding_o), 32'd1);
        chk("lw0_pend", hz.pending_o, 32'h0);
        wb(0); cyc("wb0");
        #1; chk("wb0_err", 32'(hz.err_o), 32'd1);

        // Reset mid-operation, then a stale writeback.
        rst_n = 1'b0; idle(); step();
        rst_n = 1'b1;
        drv(1, 0, 0, 13, 1, 1, 0, 0, 0); cyc("lw13");
        rst_n = 1'b0; idle(); step();
        #1;
        chk("mid_rst_pend", hz.pending_o, 32'h0);
        chk("mid_rst_err", 32'(hz.err_o), 32'd0);
        rst_n = 1'b1;
        wb(13); cyc("stale_wb");
        #1; chk("stale_err", 32'(hz.err_o), 32'd1);

        // Random traffic; writebacks always retire the oldest op.
        for (int n = 0; n < 400; n++) begin
            logic       wv;
            logic [4:0] wa;
            if (q.size() != 0) begin
                wv = ($urandom_range(0, 2) == 0);
                wa = q[0];
            end else begin
                wv = ($urandom_range(0, 15) == 0);
                wa = 5'($urandom_range(0, 31));
            end
            drv(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0), wv, wa);
            rst_n = ($urandom_range(0, 99) != 0);
            cyc("rnd");
        end
        rst_n = 1'b1;
        idle();
        cyc("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MAX_OUT, default 2: maximum number of outstanding long-latency ops (loads, div/rem).
REQ-002 Parameter CNT_W, default 2: outstanding-counter width; SHALL satisfy 2**CNT_W > MAX_OUT.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 dec_valid_i  in  1  decode stage holds a valid instruction.
REQ-006 dec_rs1_raddr_i  in  5  rs1 index from decode (0 = unused).
REQ-007 dec_rs2_raddr_i  in  5  rs2 index from decode (0 = unused).
REQ-008 dec_rd_waddr_i  in  5  rd index from decode.
REQ-009 dec_rd_we_i  in  1  instruction writes rd.
REQ-010 dec_long_i  in  1  instruction is long-latency (load, div, divu, rem, remu).
REQ-011 flush_i  in  1  pipeline flush from taken jump/branch/trap.
REQ-012 wb_valid_i  in  1  long-latency unit writes back this cycle.
REQ-013 wb_waddr_i  in  5  rd index of that writeback.
REQ-014 stall_o  out  1  hold decode; replaces the tied-off decode stall.
REQ-015 pending_o  out  32  scoreboard bitmap; bit n = xn awaiting long writeback.
REQ-016 outstanding_o  out  CNT_W  current outstanding long-op count.
REQ-017 err_o  out  1  sticky: writeback received with zero ops outstanding.

Function
REQ-018 issue = dec_valid_i & ~flush_i & ~stall_o; issue_long = issue & dec_long_i.
REQ-019 raw = (rs1!=0 & pending[rs1]) | (rs2!=0 & pending[rs2]); waw = dec_rd_we_i & rd!=0 & pending[rd].
REQ-020 full = dec_long_i & (outstanding == MAX_OUT).
REQ-021 stall_o SHALL be combinational: dec_valid_i & ~flush_i & (raw | waw | full).
REQ-022 stall_o SHALL be evaluated from registered pending/count only; a same-cycle writeback SHALL NOT release the stall (release one cycle after the wb_valid_i cycle).
REQ-023 On issue_long with dec_rd_we_i & rd!=0: pending[rd] SHALL be set at the next edge.
REQ-024 On wb_valid_i with wb_waddr_i!=0: pending[wb_waddr_i] SHALL be cleared at the next edge.
REQ-025 Same-cycle set and clear of the same index: set SHALL win.
REQ-026 pending[0] SHALL remain 0 at all times.
REQ-027 outstanding next = outstanding + issue_long - (wb_valid_i & outstanding!=0); simultaneous issue_long and wb SHALL leave it unchanged.
REQ-028 A long op with rd=0 or dec_rd_we_i=0 SHALL consume a count slot without setting a pending bit; its writeback SHALL decrement the count only.
REQ-029 wb_valid_i with outstanding==0 SHALL set err_o and leave count at 0; pending bit clear still applies.
REQ-030 flush_i SHALL force stall_o=0 and suppress issue; it SHALL NOT clear pending bits or count (in-flight ops still write back).
REQ-031 Long ops SHALL retire in issue order; the block SHALL NOT reorder or check order.

Reset
REQ-032 While rst_n=0 at an edge: pending_o=0, outstanding_o=0, err_o=0; stall_o=0 follows combinationally.
REQ-033 Reset mid-operation SHALL discard all pending state; writebacks arriving after reset with count 0 SHALL set err_o per REQ-029.

Structure
REQ-034 MAX_OUT default, GPR count (32) and the long-op class definition SHALL live in the shared defines header used by decode.
REQ-035 Single module; no sub-module is natural (bitmap and counter are each under 30 lines).
REQ-036 No path from wb_* or flush_i to stall_o except the flush_i gate.

Verification
REQ-037 lw x5 issues; next instr add x6,x5,x1 -> stall_o=1 until cycle after wb_valid_i with wb_waddr_i=5, then issues; pending_o returns to 0.
REQ-038 div x7 issues, then div x8, then div x9 (MAX_OUT=2) -> third stalls (full); wb x7 -> third issues next cycle, outstanding_o=2.
REQ-039 lw x3 pending; lw x3 again -> stall_o=1 (WAW); add x0,x3,x3 with rd=0 still stalls (RAW); addi x4,x0,1 -> no stall.
REQ-040 Pending x10 with dependent instr and flush_i=1 -> stall_o=0, no issue; pending_o[10]=1 retained.
REQ-041 Same cycle: wb x11 and issue lw x12 -> outstanding unchanged, pending_o bit11=0, bit12=1.
REQ-042 wb_valid_i with outstanding_o=0 -> err_o=1 sticky until rst_n=0; lw x0 issue -> count+1, pending_o=0.
